// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one Avalon memory port between the icache and dcache memory-side ports.
// Round-robin between the two requesters. Once a transfer is stalled by waitrequest,
// the grant stays with that requester until the transfer is accepted.
// Optional build macro CACHE_ARB_STAT_EN adds grant and contention counters (stat_* ports).
module cache_mem_arbiter #(
    parameter int STAT_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // icache memory-side port
    input  logic                    ic_avn_read,
    input  logic                    ic_avn_write,
    input  logic [ADDR_WIDTH-1:0]   ic_avn_address,
    input  logic [DATA_WIDTH/8-1:0] ic_avn_byte_enable,
    input  logic [DATA_WIDTH-1:0]   ic_avn_writedata,
    output logic [DATA_WIDTH-1:0]   ic_avn_readdata,
    output logic                    ic_avn_waitrequest,
    // dcache memory-side port
    input  logic                    dc_avn_read,
    input  logic                    dc_avn_write,
    input  logic [ADDR_WIDTH-1:0]   dc_avn_address,
    input  logic [DATA_WIDTH/8-1:0] dc_avn_byte_enable,
    input  logic [DATA_WIDTH-1:0]   dc_avn_writedata,
    output logic [DATA_WIDTH-1:0]   dc_avn_readdata,
    output logic                    dc_avn_waitrequest,
    // shared memory port
    output logic                    mem_avn_read,
    output logic                    mem_avn_write,
    output logic [ADDR_WIDTH-1:0]   mem_avn_address,
    output logic [DATA_WIDTH/8-1:0] mem_avn_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_avn_writedata,
    input  logic [DATA_WIDTH-1:0]   mem_avn_readdata,
    input  logic                    mem_avn_waitrequest
`ifdef CACHE_ARB_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0]   stat_ic_grant,
    output logic [STAT_WIDTH-1:0]   stat_dc_grant,
    output logic [STAT_WIDTH-1:0]   stat_conflict
`endif
);

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    logic   lock;
    owner_t lock_owner;
    owner_t last_grant;

    logic   ic_valid;
    logic   dc_valid;
    logic   grant_ic;
    logic   grant_dc;
    owner_t grant_owner;
    logic   xfer_valid;
    logic   accept;

    assign ic_valid = ic_avn_read | ic_avn_write;
    assign dc_valid = dc_avn_read | dc_avn_write;

    // Grant selection: locked owner first, then the single requester, then round-robin on a tie.
    // Held at no grant during reset so memory read/write drop as soon as rst_n falls.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (!rst_n) begin
            grant_ic = 1'b0;
            grant_dc = 1'b0;
        end else if (lock) begin
            grant_ic = (lock_owner == OWN_IC);
            grant_dc = (lock_owner == OWN_DC);
        end else if (ic_valid && dc_valid) begin
            grant_ic = (last_grant == OWN_DC);
            grant_dc = (last_grant == OWN_IC);
        end else if (ic_valid) begin
            grant_ic = 1'b1;
        end else if (dc_valid) begin
            grant_dc = 1'b1;
        end
    end

    assign grant_owner = grant_dc ? OWN_DC : OWN_IC;
    // A locked owner that dropped its request still holds the grant this cycle but moves nothing.
    assign xfer_valid  = (grant_ic & ic_valid) | (grant_dc & dc_valid);
    assign accept      = xfer_valid & ~mem_avn_waitrequest;

    // Forward the granted request; with no grant, pass icache fields with read/write forced low.
    always_comb begin
        mem_avn_read        = 1'b0;
        mem_avn_write       = 1'b0;
        mem_avn_address     = ic_avn_address;
        mem_avn_byte_enable = ic_avn_byte_enable;
        mem_avn_writedata   = ic_avn_writedata;
        if (grant_dc) begin
            mem_avn_read        = dc_avn_read;
            mem_avn_write       = dc_avn_write;
            mem_avn_address     = dc_avn_address;
            mem_avn_byte_enable = dc_avn_byte_enable;
            mem_avn_writedata   = dc_avn_writedata;
        end else if (grant_ic) begin
            mem_avn_read        = ic_avn_read;
            mem_avn_write       = ic_avn_write;
        end
    end

    // Responses: granted port sees memory waitrequest, a blocked requester is stalled.
    // readdata goes to both ports; each cache qualifies it with its own pending read.
    always_comb begin
        ic_avn_waitrequest = grant_ic ? mem_avn_waitrequest : ic_valid;
        dc_avn_waitrequest = grant_dc ? mem_avn_waitrequest : dc_valid;
        ic_avn_readdata    = mem_avn_readdata;
        dc_avn_readdata    = mem_avn_readdata;
    end

    // Lock on a stalled transfer, release on accept or dropped request, remember last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock       <= 1'b0;
            lock_owner <= OWN_IC;
            last_grant <= OWN_DC;
        end else begin
            lock <= xfer_valid & mem_avn_waitrequest;
            if (xfer_valid && mem_avn_waitrequest) begin
                lock_owner <= grant_owner;
            end
            if (accept) begin
                last_grant <= grant_owner;
            end
        end
    end

`ifdef CACHE_ARB_STAT_EN
    logic [STAT_WIDTH-1:0] ic_grant_cnt;
    logic [STAT_WIDTH-1:0] dc_grant_cnt;
    logic [STAT_WIDTH-1:0] conflict_cnt;
    logic                  blocked;

    assign blocked = (ic_valid & grant_dc) | (dc_valid & grant_ic);

    // Wrapping statistics counters: accepted transfers per port and contention cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_grant_cnt <= '0;
            dc_grant_cnt <= '0;
            conflict_cnt <= '0;
        end else begin
            if (accept && grant_ic) begin
                ic_grant_cnt <= ic_grant_cnt + STAT_WIDTH'(1);
            end
            if (accept && grant_dc) begin
                dc_grant_cnt <= dc_grant_cnt + STAT_WIDTH'(1);
            end
            if (blocked) begin
                conflict_cnt <= conflict_cnt + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_ic_grant = ic_grant_cnt;
    assign stat_dc_grant = dc_grant_cnt;
    assign stat_conflict = conflict_cnt;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Table-driven checks of cache_mem_arbiter plus hand-written multi-cycle sequences.
// Define CACHE_ARB_STAT_EN to also exercise the stat_* counters.
module tb_cache_mem_arbiter;

    localparam logic [31:0] IC_ADDR = 32'h0000_0100;
    localparam logic [31:0] DC_ADDR = 32'h0000_0040;
    localparam logic [31:0] IC_WD   = 32'hAAAA_0001;
    localparam logic [31:0] DC_WD   = 32'h1234_5678;
    localparam logic [3:0]  IC_BE   = 4'hF;
    localparam logic [3:0]  DC_BE   = 4'h3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_read = 1'b0, ic_write = 1'b0;
    logic        dc_read = 1'b0, dc_write = 1'b0;
    logic [31:0] ic_rdata, dc_rdata;
    logic        ic_wait, dc_wait;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_wait = 1'b0;
`ifdef CACHE_ARB_STAT_EN
    logic [31:0] stat_ic, stat_dc, stat_cf;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.STAT_WIDTH(32), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ic_avn_read        (ic_read),
        .ic_avn_write       (ic_write),
        .ic_avn_address     (IC_ADDR),
        .ic_avn_byte_enable (IC_BE),
        .ic_avn_writedata   (IC_WD),
        .ic_avn_readdata    (ic_rdata),
        .ic_avn_waitrequest (ic_wait),
        .dc_avn_read        (dc_read),
        .dc_avn_write       (dc_write),
        .dc_avn_address     (DC_ADDR),
        .dc_avn_byte_enable (DC_BE),
        .dc_avn_writedata   (DC_WD),
        .dc_avn_readdata    (dc_rdata),
        .dc_avn_waitrequest (dc_wait),
        .mem_avn_read       (mem_rd),
        .mem_avn_write      (mem_wr),
        .mem_avn_address    (mem_addr),
        .mem_avn_byte_enable(mem_be),
        .mem_avn_writedata  (mem_wdata),
        .mem_avn_readdata   (mem_rdata),
        .mem_avn_waitrequest(mem_wait)
`ifdef CACHE_ARB_STAT_EN
        ,
        .stat_ic_grant      (stat_ic),
        .stat_dc_grant      (stat_dc),
        .stat_conflict      (stat_cf)
`endif
    );

    // ic/dc fields are {read, write}; e_mem is expected {mem read, mem write};
    // e_dc selects which requester's address/data/byte-enable must appear on the memory port.
    typedef struct {
        logic [1:0] ic;
        logic [1:0] dc;
        logic       mw;
        logic [1:0] e_mem;
        logic       e_dc;
        logic       e_icw;
        logic       e_dcw;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic drive(input logic [1:0] ic, input logic [1:0] dc, input logic mw);
        ic_read  = ic[1];
        ic_write = ic[0];
        dc_read  = dc[1];
        dc_write = dc[0];
        mem_wait = mw;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [127:0] pack_exp(input vec_t v);
        return {58'd0, v.e_mem, v.e_icw, v.e_dcw,
                (v.e_dc ? DC_BE : IC_BE), (v.e_dc ? DC_WD : IC_WD), (v.e_dc ? DC_ADDR : IC_ADDR)};
    endfunction

    function automatic logic [127:0] pack_act();
        return {58'd0, mem_rd, mem_wr, ic_wait, dc_wait, mem_be, mem_wdata, mem_addr};
    endfunction

    initial begin
        logic [1:0] seq_dc[6];
        logic       seq_mw[6];
        logic [1:0] seq_mem[6];
        logic       seq_dcw[6];

        vecs[0]  = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};  // reset state, idle
        vecs[1]  = '{2'b10, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};  // lone IC read, zero latency
        vecs[2]  = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0};  // tie, last was IC -> DC
        vecs[4]  = '{2'b10, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};  // alternate -> IC
        vecs[5]  = '{2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{2'b10, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'b00, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};  // DC write stalled -> lock
        vecs[8]  = '{2'b10, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};  // IC blocked by lock
        vecs[9]  = '{2'b10, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{2'b10, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};  // DC accepted
        vecs[11] = '{2'b10, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};  // IC next cycle
        vecs[12] = '{2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};  // IC stalled -> lock
        vecs[13] = '{2'b00, 2'b10, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};  // locked IC drops request
        vecs[14] = '{2'b00, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};  // lock gone, DC served
        vecs[15] = '{2'b10, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};  // last DC -> IC

        // Table: one vector per clock, state carried across vectors.
        do_reset();
`ifdef CACHE_ARB_STAT_EN
        @(negedge clk);
        check("stat_reset", {32'd0, stat_ic, stat_dc, stat_cf}, 128'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].ic, vecs[i].dc, vecs[i].mw);
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_act(), pack_exp(vecs[i]));
        end

        // Read data passes to both ports one cycle after an accepted IC read.
        do_reset();
        @(posedge clk);
        #1 drive(2'b10, 2'b00, 1'b0);
        @(negedge clk);
        check("rd_issue", {126'd0, mem_rd, ic_wait}, {126'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1 drive(2'b00, 2'b00, 1'b0);
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rd_data", {64'd0, ic_rdata, dc_rdata}, {64'd0, 32'hCAFE_F00D, 32'hCAFE_F00D});
        mem_rdata = 32'h0;

        // Dirty miss: flush write then retrieve read, each stalled 2 cycles, IC idle.
        seq_dc  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        seq_mw  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        seq_mem = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        seq_dcw = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 drive(2'b00, seq_dc[i], seq_mw[i]);
            @(negedge clk);
            check($sformatf("dirty%0d", i), {92'd0, mem_rd, mem_wr, dc_wait, mem_addr},
                  {92'd0, seq_mem[i], seq_dcw[i], DC_ADDR});
        end
        @(posedge clk);
        #1 drive(2'b00, 2'b00, 1'b0);
`ifdef CACHE_ARB_STAT_EN
        @(negedge clk);
        check("dirty_stat", {32'd0, stat_ic, stat_dc, stat_cf}, {32'd0, 32'd0, 32'd2, 32'd0});
`endif
        @(posedge clk);
        #1 drive(2'b10, 2'b10, 1'b0);
        @(negedge clk);
        check("dirty_last", {94'd0, ic_wait, dc_wait, mem_addr}, {94'd0, 1'b0, 1'b1, IC_ADDR});

        // Reset while locked on a stalled IC read.
        do_reset();
        @(posedge clk);
        #1 drive(2'b10, 2'b00, 1'b1);
        @(negedge clk);
        check("lock_rd", {127'd0, mem_rd}, {127'd0, 1'b1});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_rd", {126'd0, mem_rd, mem_wr}, 128'd0);
        @(posedge clk);
        #1 drive(2'b10, 2'b10, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first", {94'd0, ic_wait, dc_wait, mem_addr}, {94'd0, 1'b0, 1'b1, IC_ADDR});

`ifdef CACHE_ARB_STAT_EN
        // 100 cycles of both requesting with no stall: even split, every cycle contended.
        do_reset();
        @(posedge clk);
        #1 drive(2'b10, 2'b10, 1'b0);
        repeat (100) @(posedge clk);
        #1 drive(2'b00, 2'b00, 1'b0);
        @(negedge clk);
        check("stat_100", {32'd0, stat_ic, stat_dc, stat_cf}, {32'd0, 32'd50, 32'd50, 32'd100});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
